pim_bank_port_mux: RTL and testbench
====================================

Name: pim_bank_port_mux

Overview:
- Multi-master front end of one PIM memory bank. It consumes the one-hot grant from the bank's fixed-priority arbiter and locks that grant for a whole burst.
- It drives the bank's single SRAM port with incrementing addresses and routes read data back to the owning master.
- It sits between the compute-tile request buses and the bank macro.
- It exports arb_req to the arbiter and takes arb_gnt back; the arbiter gives the highest index the highest priority.

Parameters:
- MASTERS, 2, number of requesting masters (≥1).
- ADDR_W, 16, bank word-address width.
- DATA_W, 32, data word width.
- LEN_W, 4, burst-length field width; a burst is len+1 beats, up to 16.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- m_cmd_valid  in  MASTERS  per-master command valid.
- m_cmd_ready  out  MASTERS  one-hot command accept pulse.
- m_cmd_addr  in  MASTERS×ADDR_W  burst base address.
- m_cmd_we  in  MASTERS  1 = write burst, 0 = read burst.
- m_cmd_len  in  MASTERS×LEN_W  beats minus one.
- m_wdata  in  MASTERS×DATA_W  write beat data.
- m_wready  out  MASTERS  write beat consumed this cycle.
- m_rsp_valid  out  MASTERS  read beat valid.
- m_rsp_data  out  DATA_W  read data, shared by all masters and qualified by m_rsp_valid.
- arb_req  out  MASTERS  request vector to the arbiter.
- arb_gnt  in  MASTERS  combinational one-hot grant from the arbiter.
- mem_en  out  1  bank access enable.
- mem_we  out  1  bank write enable.
- mem_addr  out  ADDR_W  bank address.
- mem_wdata  out  DATA_W  bank write data.
- mem_rdata  in  DATA_W  bank read data, valid the cycle after a read with mem_en=1.

Behaviour:
- Reset values:
  - State IDLE.
  - m_cmd_ready=0, m_wready=0, m_rsp_valid=0, m_rsp_data=0.
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - Internal owner, beat counter and address registers = 0.
- Reset mid-burst aborts the burst. No further responses are produced and no partial-burst state survives.
- FSM states: IDLE, BURST, DRAIN.
- IDLE:
  - arb_req = m_cmd_valid.
  - If arb_gnt≠0, assert m_cmd_ready[g] combinationally in the same cycle, where g is the index of the set arb_gnt bit.
  - On that edge, latch owner=g, addr=m_cmd_addr[g], we=m_cmd_we[g], remaining=m_cmd_len[g], then go to BURST.
  - If arb_gnt is not one-hot or grants a non-requesting master, it is ignored and the block stays in IDLE. The verification bench asserts this never happens.
- BURST (one beat per cycle, no stalls):
  - arb_req=0, so the grant stays locked and lower-priority masters cannot preempt.
  - mem_en=1, mem_we=we, mem_addr=addr.
  - Writes:
    - mem_wdata = m_wdata[owner].
    - m_wready[owner]=1.
    - The master must hold valid data on every beat; there is no write backpressure.
  - After each beat, addr increments modulo 2^ADDR_W, so 0xFFFF wraps to 0x0000 within a burst.
  - When remaining==0 on a beat:
    - Read burst: go to DRAIN.
    - Write burst: go to IDLE.
  - Otherwise remaining decrements.
- Read return path:
  - A registered pipe tracks "read issued last cycle".
  - In the cycle after each read beat: m_rsp_valid[owner]=1 and m_rsp_data=mem_rdata.
  - Read response latency is 2 cycles after the command-accept cycle.
- DRAIN:
  - Lasts one cycle and delivers the last read response.
  - mem_en=0 and arb_req=0.
  - Then go to IDLE.
- Timing and throughput:
  - Cycles between consecutive commands: write burst = len+2; read burst = len+3 (one arbitration cycle in IDLE plus DRAIN).
- Simultaneous events:
  - Requests from the same or other masters during BURST/DRAIN are not forwarded to the arbiter.
  - A master may drop m_cmd_valid before acceptance without side effects.
  - len=0 produces exactly one beat.

Decomposition:
- Package pim_bank_pkg:
  - typedef state_e {IDLE, BURST, DRAIN}.
  - Default widths ADDR_W, DATA_W, LEN_W.
  - Helper function onehot_to_idx.
- One sub-module, pim_bank_rsp_pipe: one-cycle valid/owner register that produces m_rsp_valid and m_rsp_data.
- The arbiter is instantiated at the top level, not inside this block.

Test Plan:
- Single read: master0 addr=0x0010, len=3, bank preloaded with mem[i]=i → accept in cycle 0; mem_addr 0x10–0x13 in cycles 1–4; m_rsp_valid[0] in cycles 2–5 with data 0x10–0x13; back in IDLE at cycle 6.
- Write burst: master1 addr=0x0100, len=1, wdata 0xA5A5A5A5 then 0x5A5A5A5A → m_wready[1] in cycles 1–2; bank holds both words; no m_rsp_valid.
- Priority and lock:
  - Both masters request in the same cycle → master1 is granted first.
  - During master1's 4-beat burst arb_req=0; master0 is accepted in the first IDLE cycle afterwards.
  - Master0 requests mid-burst while master1's 16-beat burst is active → no preemption; all 16 beats stay on master1.
- Address wrap: read addr=0xFFFE, len=3 → mem_addr sequence FFFE, FFFF, 0000, 0001.
- Reset mid-read: assert rst_n=0 at beat 2 of a len=7 read → all outputs 0 immediately; after release, no stray m_rsp_valid and the block is in IDLE.
- Zero-length: len=0 read → exactly one mem_en cycle and exactly one response beat.

Source files
------------

// File: rtl/pim_bank_pkg.sv
// Shared types, default widths and helpers for the PIM bank port multiplexer.
package pim_bank_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_LEN_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Index of the highest set bit of a one-hot vector (up to 32 masters).
    function automatic logic [4:0] onehot_to_idx(input logic [31:0] vec);
        logic [4:0] idx;
        idx = '0;
        for (int i = 0; i < 32; i++) begin
            if (vec[i]) idx = 5'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/pim_bank_rsp_pipe.sv
// One-cycle read-return register: remembers that a read beat was issued and
// for whom, then steers the bank's read data back to that master.
module pim_bank_rsp_pipe
    import pim_bank_pkg::*;
#(
    parameter int MASTERS = 2,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int OW      = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rd_issue,
    input  logic [OW-1:0]      rd_owner,
    input  logic [DATA_W-1:0]  mem_rdata,
    output logic [MASTERS-1:0] m_rsp_valid,
    output logic [DATA_W-1:0]  m_rsp_data
);

    logic          pend;
    logic [OW-1:0] pend_owner;

    // Track "read issued last cycle" and the master that issued it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend       <= 1'b0;
            pend_owner <= '0;
        end else begin
            pend <= rd_issue;
            if (rd_issue) pend_owner <= rd_owner;
        end
    end

    // Qualify the shared data bus with a one-hot valid towards the owner.
    always_comb begin
        m_rsp_valid = '0;
        m_rsp_data  = '0;
        if (pend) begin
            m_rsp_valid[pend_owner] = 1'b1;
            m_rsp_data              = mem_rdata;
        end
    end

endmodule

// File: rtl/pim_bank_port_mux.sv
// Multi-master front end of one PIM bank: locks the arbiter's grant for a whole
// burst, drives the single SRAM port with incrementing addresses and returns
// read beats to the owning master.
//
// Handshake: a command is taken in the cycle m_cmd_valid[i] and m_cmd_ready[i]
// are both high; ready is a one-cycle pulse raised only in IDLE for the granted
// master. Write beats have no backpressure: m_wready[owner] marks the cycle the
// beat is consumed. Read beats carry no ready either: m_rsp_valid[owner] marks
// the cycle m_rsp_data holds a beat.
module pim_bank_port_mux
    import pim_bank_pkg::*;
#(
    parameter int MASTERS = 2,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int LEN_W   = DEF_LEN_W
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [MASTERS-1:0]             m_cmd_valid,
    output logic [MASTERS-1:0]             m_cmd_ready,
    input  logic [MASTERS-1:0][ADDR_W-1:0] m_cmd_addr,
    input  logic [MASTERS-1:0]             m_cmd_we,
    input  logic [MASTERS-1:0][LEN_W-1:0]  m_cmd_len,
    input  logic [MASTERS-1:0][DATA_W-1:0] m_wdata,
    output logic [MASTERS-1:0]             m_wready,
    output logic [MASTERS-1:0]             m_rsp_valid,
    output logic [DATA_W-1:0]              m_rsp_data,
    output logic [MASTERS-1:0]             arb_req,
    input  logic [MASTERS-1:0]             arb_gnt,
    output logic                           mem_en,
    output logic                           mem_we,
    output logic [ADDR_W-1:0]              mem_addr,
    output logic [DATA_W-1:0]              mem_wdata,
    input  logic [DATA_W-1:0]              mem_rdata,
    output state_e                         dbg_state
);

    localparam int OW = (MASTERS > 1) ? $clog2(MASTERS) : 1;

    state_e            state, state_nxt;
    logic [OW-1:0]     owner;
    logic [ADDR_W-1:0] addr;
    logic              burst_we;
    logic [LEN_W-1:0]  remaining;
    logic              gnt_ok;
    logic [OW-1:0]     gnt_idx;
    logic              accept;

    // A grant counts only if it is one-hot and points at a requesting master.
    assign gnt_ok  = (arb_gnt != '0)
                  && ((arb_gnt & (arb_gnt - MASTERS'(1))) == '0)
                  && ((arb_gnt & ~m_cmd_valid) == '0);
    assign gnt_idx = OW'(onehot_to_idx(32'(arb_gnt)));
    assign accept  = (state == IDLE) && gnt_ok;

    assign dbg_state = state;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Burst context: latched on accept, address and beat count advance per beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner     <= '0;
            addr      <= '0;
            burst_we  <= 1'b0;
            remaining <= '0;
        end else if (accept) begin
            owner     <= gnt_idx;
            addr      <= m_cmd_addr[gnt_idx];
            burst_we  <= m_cmd_we[gnt_idx];
            remaining <= m_cmd_len[gnt_idx];
        end else if (state == BURST) begin
            addr <= addr + ADDR_W'(1);
            if (remaining != '0) remaining <= remaining - LEN_W'(1);
        end
    end

    // Next state and all port-side outputs; arbiter only sees requests in IDLE.
    always_comb begin
        state_nxt   = state;
        arb_req     = '0;
        m_cmd_ready = '0;
        m_wready    = '0;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        case (state)
            IDLE: begin
                arb_req = m_cmd_valid;
                if (gnt_ok) begin
                    m_cmd_ready = arb_gnt;
                    state_nxt   = BURST;
                end
            end
            BURST: begin
                mem_en   = 1'b1;
                mem_we   = burst_we;
                mem_addr = addr;
                if (burst_we) begin
                    mem_wdata       = m_wdata[owner];
                    m_wready[owner] = 1'b1;
                end
                if (remaining == '0) state_nxt = burst_we ? IDLE : DRAIN;
            end
            DRAIN: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    pim_bank_rsp_pipe #(
        .MASTERS(MASTERS),
        .DATA_W (DATA_W),
        .OW     (OW)
    ) u_rsp_pipe (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_issue   ((state == BURST) && !burst_we),
        .rd_owner   (owner),
        .mem_rdata  (mem_rdata),
        .m_rsp_valid(m_rsp_valid),
        .m_rsp_data (m_rsp_data)
    );

endmodule

// File: tb/tb_pim_bank_port_mux.sv
// Bench for pim_bank_port_mux: bank SRAM and fixed-priority arbiter models,
// a burst-schedule reference model, directed scenarios and random traffic.
module tb_pim_bank_port_mux;
    import pim_bank_pkg::*;

    localparam int M  = 2;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int LW = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic [M-1:0]         m_cmd_valid, m_cmd_ready, m_cmd_we, m_wready, m_rsp_valid;
    logic [M-1:0]         arb_req, arb_gnt;
    logic [M-1:0][AW-1:0] m_cmd_addr;
    logic [M-1:0][LW-1:0] m_cmd_len;
    logic [M-1:0][DW-1:0] m_wdata;
    logic [DW-1:0]        m_rsp_data, mem_wdata, mem_rdata;
    logic                 mem_en, mem_we;
    logic [AW-1:0]        mem_addr;
    state_e               dbg_state;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    pim_bank_port_mux #(.MASTERS(M), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
        .clk(clk), .rst_n(rst_n),
        .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready), .m_cmd_addr(m_cmd_addr),
        .m_cmd_we(m_cmd_we), .m_cmd_len(m_cmd_len), .m_wdata(m_wdata),
        .m_wready(m_wready), .m_rsp_valid(m_rsp_valid), .m_rsp_data(m_rsp_data),
        .arb_req(arb_req), .arb_gnt(arb_gnt),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
    );

    // Fixed-priority arbiter: highest index wins.
    always_comb begin
        arb_gnt = '0;
        for (int m = 0; m < M; m++) begin
            if (arb_req[m]) arb_gnt = M'(1) << m;
        end
    end

    // Bank SRAM: one-cycle read latency.
    logic [DW-1:0] env_mem [0:65535];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) env_mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= env_mem[mem_addr];
        end
    end

    // ---------------- reference model ----------------
    typedef struct {
        logic          drain;
        logic          we;
        logic [AW-1:0] addr;
        int            owner;
    } slot_t;

    slot_t         sched[$];     // one entry per future busy cycle
    logic [DW-1:0] exp_q[$];     // expected read-return data
    int            own_q[$];     // owner of each expected read return
    logic [DW-1:0] ref_mem [0:65535];
    logic [M-1:0]  acc_mask;

    int n_chk  = 0;
    int n_pass = 0;

    // Sampled DUT outputs of the last ticked cycle, for literal checks.
    logic [M-1:0]  s_ready, s_wready, s_rsp_valid, s_arb_req;
    logic [AW-1:0] s_mem_addr;
    logic [DW-1:0] s_rsp_data;
    logic          s_mem_en;
    state_e        s_state;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // One clock cycle: predict this cycle's outputs, compare, advance model.
    task automatic tick();
        slot_t         cur;
        bit            busy;
        logic [M-1:0]  e_req, e_rdy, e_wr, e_rv;
        logic          e_en, e_we;
        logic [AW-1:0] e_addr, a;
        logic [DW-1:0] e_wd, e_rd;
        state_e        e_st;
        int            g;
        #1;
        e_req = '0; e_rdy = '0; e_wr = '0; e_rv = '0;
        e_en = 1'b0; e_we = 1'b0; e_addr = '0; e_wd = '0; e_rd = '0;
        e_st = IDLE; g = 0;
        cur = '{drain: 1'b0, we: 1'b0, addr: '0, owner: 0};
        if (exp_q.size() > 0) begin
            e_rd = exp_q.pop_front();
            e_rv[own_q.pop_front()] = 1'b1;
        end
        busy = (sched.size() > 0);
        if (busy) begin
            cur = sched.pop_front();
            if (cur.drain) e_st = DRAIN;
            else begin
                e_st = BURST; e_en = 1'b1; e_we = cur.we; e_addr = cur.addr;
                if (cur.we) begin
                    e_wd = m_wdata[cur.owner];
                    e_wr[cur.owner] = 1'b1;
                end
            end
        end else begin
            e_req = m_cmd_valid;
            if (m_cmd_valid != '0) begin
                for (int m = 0; m < M; m++) if (m_cmd_valid[m]) g = m;
                e_rdy[g] = 1'b1;
                a = m_cmd_addr[g];
                for (int b = 0; b <= int'(m_cmd_len[g]); b++) begin
                    sched.push_back('{drain: 1'b0, we: m_cmd_we[g], addr: a, owner: g});
                    a = a + 16'd1;
                end
                if (!m_cmd_we[g]) sched.push_back('{drain: 1'b1, we: 1'b0, addr: '0, owner: g});
            end
        end
        chk("arb_req",   64'(arb_req),     64'(e_req));
        chk("cmd_ready", 64'(m_cmd_ready), 64'(e_rdy));
        chk("wready",    64'(m_wready),    64'(e_wr));
        chk("rsp_valid", 64'(m_rsp_valid), 64'(e_rv));
        if (e_rv != '0) chk("rsp_data", 64'(m_rsp_data), 64'(e_rd));
        chk("mem_en",    64'(mem_en),      64'(e_en));
        if (e_en) begin
            chk("mem_we",   64'(mem_we),   64'(e_we));
            chk("mem_addr", 64'(mem_addr), 64'(e_addr));
        end
        if (e_en && e_we) chk("mem_wdata", 64'(mem_wdata), 64'(e_wd));
        chk("state", 64'(dbg_state), 64'(e_st));
        if (busy && !cur.drain) begin
            if (cur.we) ref_mem[cur.addr] = e_wd;
            else begin
                exp_q.push_back(ref_mem[cur.addr]);
                own_q.push_back(cur.owner);
            end
        end
        acc_mask    = e_rdy;
        s_ready     = m_cmd_ready;
        s_wready    = m_wready;
        s_rsp_valid = m_rsp_valid;
        s_arb_req   = arb_req;
        s_mem_addr  = mem_addr;
        s_rsp_data  = m_rsp_data;
        s_mem_en    = mem_en;
        s_state     = dbg_state;
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ready"},     64'(m_cmd_ready), 64'(0));
        chk({tag, "_wready"},    64'(m_wready),    64'(0));
        chk({tag, "_rsp_valid"}, 64'(m_rsp_valid), 64'(0));
        chk({tag, "_rsp_data"},  64'(m_rsp_data),  64'(0));
        chk({tag, "_mem_en"},    64'(mem_en),      64'(0));
        chk({tag, "_mem_we"},    64'(mem_we),      64'(0));
        chk({tag, "_mem_addr"},  64'(mem_addr),    64'(0));
        chk({tag, "_mem_wdata"}, 64'(mem_wdata),   64'(0));
        chk({tag, "_state"},     64'(dbg_state),   64'(IDLE));
    endtask

    task automatic set_cmd(input int m, input logic [AW-1:0] a, input logic we, input logic [LW-1:0] len);
        m_cmd_valid[m] = 1'b1;
        m_cmd_addr[m]  = a;
        m_cmd_we[m]    = we;
        m_cmd_len[m]   = len;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int first_rdy, cnt_a, cnt_b;
        logic [AW-1:0] wrap_exp [4];
        wrap_exp = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        rst_n = 1'b1;
        m_cmd_valid = '0; m_cmd_addr = '0; m_cmd_we = '0; m_cmd_len = '0; m_wdata = '0;
        acc_mask = '0;
        for (int i = 0; i < 65536; i++) begin
            env_mem[i] = 32'(i);
            ref_mem[i] = 32'(i);
        end
        #2 rst_n = 1'b0;
        #1 check_all_zero("reset");
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // Single read: master0, 0x0010, 4 beats.
        set_cmd(0, 16'h0010, 1'b0, 4'd3);
        for (int c = 0; c < 8; c++) begin
            if (c == 1) m_cmd_valid = '0;
            tick();
            if (c == 0) chk("rd_accept", 64'(s_ready), 64'(2'b01));
            if (c >= 1 && c <= 4) chk("rd_addr", 64'(s_mem_addr), 64'(16'h0010 + c - 1));
            if (c >= 2 && c <= 5) begin
                chk("rd_rsp_valid", 64'(s_rsp_valid), 64'(2'b01));
                chk("rd_rsp_data",  64'(s_rsp_data),  64'(32'h10 + c - 2));
            end
            if (c == 6) chk("rd_idle", 64'(s_state), 64'(IDLE));
        end

        // Write burst: master1, 0x0100, two beats.
        set_cmd(1, 16'h0100, 1'b1, 4'd1);
        for (int c = 0; c < 5; c++) begin
            if (c == 1) begin m_cmd_valid = '0; m_wdata[1] = 32'hA5A5A5A5; end
            if (c == 2) m_wdata[1] = 32'h5A5A5A5A;
            tick();
            if (c == 1 || c == 2) chk("wr_wready", 64'(s_wready), 64'(2'b10));
        end
        chk("wr_word0", 64'(env_mem[16'h0100]), 64'(32'hA5A5A5A5));
        chk("wr_word1", 64'(env_mem[16'h0101]), 64'(32'h5A5A5A5A));

        // Priority and lock: simultaneous requests, master1 wins.
        set_cmd(1, 16'h0200, 1'b1, 4'd3);
        set_cmd(0, 16'h0300, 1'b0, 4'd0);
        for (int c = 0; c < 10; c++) begin
            m_wdata[1] = $urandom;
            if (c == 1) m_cmd_valid[1] = 1'b0;
            if (c == 6) m_cmd_valid[0] = 1'b0;
            tick();
            if (c == 0) chk("prio_first", 64'(s_ready), 64'(2'b10));
            if (c >= 1 && c <= 4) chk("prio_lock_req", 64'(s_arb_req), 64'(0));
            if (c == 5) chk("prio_second", 64'(s_ready), 64'(2'b01));
        end

        // No preemption of a 16-beat read by a mid-burst request.
        set_cmd(1, 16'h0500, 1'b0, 4'd15);
        first_rdy = -1; cnt_a = 0;
        for (int c = 0; c < 24; c++) begin
            if (c == 1) m_cmd_valid[1] = 1'b0;
            if (c == 3) set_cmd(0, 16'h0600, 1'b0, 4'd0);
            if (first_rdy >= 0) m_cmd_valid[0] = 1'b0;
            tick();
            if (s_ready[0] && first_rdy < 0) first_rdy = c;
            if (s_rsp_valid[1]) cnt_a++;
        end
        chk("nopreempt_accept", 64'(first_rdy), 64'(18));
        chk("nopreempt_beats",  64'(cnt_a),     64'(16));

        // Address wrap inside a burst.
        set_cmd(1, 16'hFFFE, 1'b0, 4'd3);
        for (int c = 0; c < 7; c++) begin
            if (c == 1) m_cmd_valid = '0;
            tick();
            if (c >= 1 && c <= 4) chk("wrap_addr", 64'(s_mem_addr), 64'(wrap_exp[c-1]));
        end

        // Zero-length read: one bank access, one response.
        set_cmd(0, 16'h0777, 1'b0, 4'd0);
        cnt_a = 0; cnt_b = 0;
        for (int c = 0; c < 5; c++) begin
            if (c == 1) m_cmd_valid = '0;
            tick();
            if (s_mem_en) cnt_a++;
            if (s_rsp_valid[0]) cnt_b++;
        end
        chk("len0_mem_en", 64'(cnt_a), 64'(1));
        chk("len0_rsp",    64'(cnt_b), 64'(1));

        // Reset during beat 2 of an 8-beat read.
        set_cmd(0, 16'h0040, 1'b0, 4'd7);
        tick();
        m_cmd_valid = '0;
        tick();
        rst_n = 1'b0;
        #1 check_all_zero("midrst");
        chk("midrst_arb_req", 64'(arb_req), 64'(0));
        sched.delete(); exp_q.delete(); own_q.delete();
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        cnt_b = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (s_rsp_valid != '0) cnt_b++;
        end
        chk("midrst_no_stray", 64'(cnt_b), 64'(0));
        chk("midrst_idle",     64'(s_state), 64'(IDLE));

        // Random traffic against the model.
        for (int c = 0; c < 2500; c++) begin
            for (int m = 0; m < M; m++) begin
                if (acc_mask[m] || (m_cmd_valid[m] && $urandom_range(0, 19) == 0))
                    m_cmd_valid[m] = 1'b0;
                else if (!m_cmd_valid[m] && $urandom_range(0, 3) == 0)
                    set_cmd(m, 16'($urandom), 1'($urandom_range(0, 1)),
                            ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15))
                                                        : 4'($urandom_range(0, 3)));
                m_wdata[m] = $urandom;
            end
            tick();
        end
        m_cmd_valid = '0;
        for (int c = 0; c < 20; c++) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
